// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display scanner.
package stopwatch_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    localparam digit_idx_t DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);

    typedef enum logic {
        BlinkOff = 1'b0,
        BlinkOn  = 1'b1
    } blink_phase_e;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [NUM_DIGITS-1:0] an_select(input digit_idx_t idx);
        an_select = ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
// Non-decimal codes render as a dash.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        unique case (bcd_i)
            4'd0:    seg_o = 7'h40;
            4'd1:    seg_o = 7'h79;
            4'd2:    seg_o = 7'h24;
            4'd3:    seg_o = 7'h30;
            4'd4:    seg_o = 7'h19;
            4'd5:    seg_o = 7'h12;
            4'd6:    seg_o = 7'h02;
            4'd7:    seg_o = 7'h78;
            4'd8:    seg_o = 7'h00;
            4'd9:    seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment scanner with frame snapshot, leading-zero
// blanking, per-digit decimal points and whole-display blinking.
module stopwatch_display_scan
    import stopwatch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [FW-1:0] frame_q, frame_d;
    blink_phase_e  phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       tick;
    logic       wrap;
    logic [3:0] cur_bcd;
    logic [6:0] cur_seg;
    logic [3:0] lz;

    // Scan timing: prescaler, digit index, snapshot and blink cadence.
    always_comb begin
        tick    = (presc_q == PW'(REFRESH_DIV - 1));
        wrap    = tick && (idx_q == DIGIT_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = tick ? idx_q + 1'b1 : idx_q;
        snap_d  = wrap ? digits : snap_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = (phase_q == BlinkOn) ? BlinkOff : BlinkOn;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    assign lz[3] = (snap_q[15:12] == 4'd0);
    assign lz[2] = (snap_q[15:8] == 8'd0);
    assign lz[1] = (snap_q[15:4] == 12'd0);
    assign lz[0] = 1'b0;

    assign cur_bcd = snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

    // The edge that advances the index produces a dead cycle to avoid ghosting.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!tick && !(blink_en && (phase_q == BlinkOff))) begin
            an_d  = an_select(idx_q);
            seg_d = (blank_lz && lz[idx_q]) ? SEG_BLANK : cur_seg;
            dp_d  = ~dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            frame_q <= '0;
            phase_q <= BlinkOn;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench for stopwatch_display_scan with REFRESH_DIV = 4, BLINK_FRAMES = 2.
module tb_stopwatch_display_scan;

    localparam int unsigned REFRESH_DIV  = 4;
    localparam int unsigned BLINK_FRAMES = 2;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         chk_seg;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   frame_k = 0;

    stopwatch_display_scan #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digits   (digits),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [3:0] a, input logic [6:0] s, input logic d,
                              input bit chk);
        exp_t e;
        e.an      = a;
        e.seg     = s;
        e.dp      = d;
        e.chk_seg = chk;
        sb.push_back(e);
    endtask

    // One frame: per digit three lit cycles followed by the dead cycle after its tick.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpm);
        logic [6:0] s [4];
        logic [3:0] sel;
        bit         off;
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        s[3] = s3;
        off  = blink_en && (((frame_k / 2) % 2) == 1);
        for (int d = 0; d < 4; d++) begin
            sel = 4'(1 << d);
            for (int c = 0; c < 3; c++) begin
                if (off) push_entry(4'b1111, 7'h7F, 1'b1, 1'b0);
                else     push_entry(~sel, s[d], ~dpm[d], 1'b1);
            end
            push_entry(4'b1111, 7'h7F, 1'b1, 1'b1);
        end
        frame_k++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        digits   = 16'h0000;
        dp_mask  = 4'b0000;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
                $display("FAIL reset[%0d]: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1",
                         i, an, seg, dp);
            end else begin
                passed++;
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            $display("FAIL reset_release: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1",
                     an, seg, dp);
        end else begin
            passed++;
        end
        frame_k = 0;
    endtask

    task automatic test_scan();
        exp_t e;
        digits = 16'h1234;
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL scan[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_blank_lz();
        exp_t e;
        digits   = 16'h0050;
        blank_lz = 1'b1;
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
        push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b0000);
        push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b0000);
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL blank_lz[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
            if (n == 31) digits = 16'h0000;
        end
    endtask

    task automatic test_invalid_dp();
        exp_t e;
        blank_lz = 1'b0;
        digits   = 16'hF0A9;
        dp_mask  = 4'b0100;
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0100);
        push_frame(7'h10, 7'h3F, 7'h40, 7'h3F, 4'b0100);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL invalid_dp[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        dp_mask = 4'b0000;
        digits  = 16'h5678;
        push_frame(7'h10, 7'h3F, 7'h40, 7'h3F, 4'b0000);
        push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b0000);
        push_frame(7'h24, 7'h79, 7'h40, 7'h10, 4'b0000);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL snapshot[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
            // Second frame, digit 1 lit: change the input mid-frame.
            if (n == 20) digits = 16'h9012;
        end
    endtask

    task automatic test_blink();
        exp_t e;
        blink_en = 1'b1;
        dp_mask  = 4'b1111;
        for (int f = 0; f < 5; f++) push_frame(7'h24, 7'h79, 7'h40, 7'h10, 4'b1111);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL blink[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
        end
        blink_en = 1'b0;
        dp_mask  = 4'b0000;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        for (int c = 0; c < 3; c++) push_entry(4'b1110, 7'h24, 1'b1, 1'b1);
        push_entry(4'b1111, 7'h7F, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) push_entry(4'b1101, 7'h79, 1'b1, 1'b1);
        push_entry(4'b1111, 7'h7F, 1'b1, 1'b1);
        push_entry(4'b1011, 7'h40, 1'b1, 1'b1);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL mid_reset_pre[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            $display("FAIL mid_reset: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1",
                     an, seg, dp);
        end else begin
            passed++;
        end
        rst     = 1'b0;
        frame_k = 0;
        // Exactly three lit cycles before the first dead cycle shows the prescaler restarted.
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        push_frame(7'h24, 7'h79, 7'h40, 7'h10, 4'b0000);
        for (int n = 0; sb.size() > 0; n++) begin
            e = sb.pop_front();
            step();
            checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                $display("FAIL mid_reset_post[%0d]: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_lz();
        test_invalid_dp();
        test_snapshot();
        test_blink();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
